// File: rtl/mux_arb_reg.sv
// N-channel W-bit selector with one registered output stage.
// MODE=0 steers by S; MODE=1 arbitrates round-robin among valid channels.
module mux_arb_reg #(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic            Clk,
  input  logic            Clrn,
  input  logic            MODE,
  input  logic [SW-1:0]   S,
  input  logic [N*W-1:0]  A,
  input  logic [N-1:0]    AVALID,
  output logic [N-1:0]    AREADY,
  output logic [W-1:0]    Y,
  output logic            YVALID,
  input  logic            YREADY,
  output logic [SW-1:0]   YSEL
);

  logic [W-1:0]   y_q, y_d;
  logic           yvalid_q, yvalid_d;
  logic [SW-1:0]  ysel_q, ysel_d;
  logic [SW-1:0]  ptr_q, ptr_d;

  logic           acc;
  logic           xfer;
  logic           gnt_vld;
  logic [SW-1:0]  gnt_idx;
  logic [W-1:0]   gnt_data;
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  int             first;
  int             gsum;

  // Rotate requests so bit 0 is the channel at PTR; the lowest set bit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    first   = 0;
    gsum    = 0;
    req_dbl = {AVALID, AVALID} >> ptr_q;
    req_rot = req_dbl[N-1:0];
    if (!MODE) begin
      for (int i = 0; i < N; i++) begin
        if (S == SW'(i) && AVALID[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SW'(i);
        end
      end
    end else begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req_rot[k]) begin
          gnt_vld = 1'b1;
          first   = k;
        end
      end
      gsum = int'(ptr_q) + first;
      if (gsum >= N) gsum = gsum - N;
      if (gnt_vld) gnt_idx = SW'(gsum);
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SW'(i)) gnt_data = A[i*W +: W];
    end
  end

  assign acc  = !yvalid_q || YREADY;
  assign xfer = Clrn && gnt_vld && acc;

  always_comb begin
    AREADY = '0;
    for (int i = 0; i < N; i++) begin
      AREADY[i] = xfer && (gnt_idx == SW'(i));
    end
  end

  always_comb begin
    y_d      = y_q;
    yvalid_d = yvalid_q;
    ysel_d   = ysel_q;
    ptr_d    = ptr_q;
    if (xfer) begin
      y_d      = gnt_data;
      ysel_d   = gnt_idx;
      yvalid_d = 1'b1;
      if (MODE) ptr_d = (gnt_idx == SW'(N - 1)) ? '0 : gnt_idx + SW'(1);
    end else if (yvalid_q && YREADY) begin
      yvalid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      y_q      <= '0;
      yvalid_q <= 1'b0;
      ysel_q   <= '0;
      ptr_q    <= '0;
    end else begin
      y_q      <= y_d;
      yvalid_q <= yvalid_d;
      ysel_q   <= ysel_d;
      ptr_q    <= ptr_d;
    end
  end

  assign Y      = y_q;
  assign YVALID = yvalid_q;
  assign YSEL   = ysel_q;

endmodule
